// File: rtl/logic_pipe_pkg.sv
// logic_pipe_pkg: function-select encoding and the two bitwise evaluation
// steps shared by the pipeline stages. The helpers work on MAX_W-bit vectors
// so any WIDTH up to MAX_W can call them with zero-extended operands and
// truncate the result.
package logic_pipe_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    AND_OR  = 2'b00,
    OR_AND  = 2'b01,
    XOR_AND = 2'b10,
    NAND_OR = 2'b11
  } mode_e;

  // First logic level: combine in1 and in2 according to the selected function.
  function automatic logic [MAX_W-1:0] stage1_eval(
    input mode_e            mode,
    input logic [MAX_W-1:0] in1,
    input logic [MAX_W-1:0] in2
  );
    logic [MAX_W-1:0] w_res;
    case (mode)
      AND_OR:  w_res = in1 | in2;
      OR_AND:  w_res = in1 & in2;
      XOR_AND: w_res = in1 ^ in2;
      NAND_OR: w_res = in1 | in2;
      default: w_res = {MAX_W{1'b0}};
    endcase
    return w_res;
  endfunction

  // Second logic level: merge sig1 with sig2 (= ~in3), or NAND with in3 directly.
  function automatic logic [MAX_W-1:0] stage2_eval(
    input mode_e            mode,
    input logic [MAX_W-1:0] sig1,
    input logic [MAX_W-1:0] sig2,
    input logic [MAX_W-1:0] in3
  );
    logic [MAX_W-1:0] w_res;
    case (mode)
      AND_OR:  w_res = sig1 & sig2;
      OR_AND:  w_res = sig1 | sig2;
      XOR_AND: w_res = sig1 & sig2;
      NAND_OR: w_res = ~(sig1 & in3);
      default: w_res = {MAX_W{1'b0}};
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/logic_pipe_if.sv
// logic_pipe_if: operand/result valid-ready bus. master = operand producer
// and result consumer; slave = the pipeline.
interface logic_pipe_if #(
  parameter int WIDTH = 8
);
  import logic_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  mode_e            mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;

  modport master (
    output in_valid, mode, in1, in2, in3, out_ready,
    input  in_ready, out_valid, out1
  );

  modport slave (
    input  in_valid, mode, in1, in2, in3, out_ready,
    output in_ready, out_valid, out1
  );

endinterface

// File: rtl/logic_pipe_popcount.sv
// logic_pipe_popcount: combinational count of set bits in i_data.
module logic_pipe_popcount #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 4
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [OUT_W-1:0] o_count
);

  // Sum the individual bits of the input vector.
  always_comb begin
    o_count = {OUT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: two-stage valid/ready pipeline evaluating a selectable
// two-level bitwise logic function, plus a saturating counter of result
// bits delivered downstream. WIDTH must not exceed logic_pipe_pkg::MAX_W.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  logic_pipe_if.slave       bus,
  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_hit_cnt
);

  localparam int               POP_W       = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX   = {CNT_W{1'b1}};

  // Stage 1 state
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_sig1;
  logic [WIDTH-1:0] r_sig2;
  logic [WIDTH-1:0] r_in3;
  mode_e            r_mode;

  // Stage 2 state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out1;

  // Counter state
  logic [CNT_W-1:0] r_hit_cnt;

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_deliver;
  logic [WIDTH-1:0] w_sig1;
  logic [WIDTH-1:0] w_out1;
  logic [POP_W-1:0] w_pop;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_next;

  // A stage may take new contents when it is empty or its contents move on.
  assign w_s2_load = ~r_s2_valid | bus.out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign w_deliver = r_s2_valid & bus.out_ready;

  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_s2_valid;
  assign bus.out1      = r_out1;
  assign o_hit_cnt     = r_hit_cnt;

  assign w_sig1 = WIDTH'(stage1_eval(bus.mode, MAX_W'(bus.in1), MAX_W'(bus.in2)));
  assign w_out1 = WIDTH'(stage2_eval(r_mode, MAX_W'(r_sig1), MAX_W'(r_sig2), MAX_W'(r_in3)));

  // Stage 1: capture first-level result, inverted in3 and the function select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_sig1     <= {WIDTH{1'b0}};
      r_sig2     <= {WIDTH{1'b0}};
      r_in3      <= {WIDTH{1'b0}};
      r_mode     <= AND_OR;
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sig1 <= w_sig1;
        r_sig2 <= ~bus.in3;
        r_in3  <= bus.in3;
        r_mode <= bus.mode;
      end
    end
  end

  // Stage 2: capture the final result; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out1     <= {WIDTH{1'b0}};
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out1 <= w_out1;
      end
    end
  end

  logic_pipe_popcount #(
    .WIDTH (WIDTH),
    .OUT_W (POP_W)
  ) u_popcount (
    .i_data  (r_out1),
    .o_count (w_pop)
  );

  // Widened sum clamps to the all-ones value instead of wrapping.
  always_comb begin
    w_sum = {1'b0, r_hit_cnt} + (CNT_W + 1)'(w_pop);
    if (w_sum > {1'b0, L_CNT_MAX}) begin
      w_cnt_next = L_CNT_MAX;
    end else begin
      w_cnt_next = w_sum[CNT_W-1:0];
    end
  end

  // Hit counter: clear wins over a same-cycle delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt <= {CNT_W{1'b0}};
    end else if (i_clr_cnt) begin
      r_hit_cnt <= {CNT_W{1'b0}};
    end else if (w_deliver) begin
      r_hit_cnt <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: two instances share one stimulus stream; u_dut16 has a
// 16-bit hit counter, u_dut4 a 4-bit one for the saturation scenarios.
module tb_logic_pipe;
  import logic_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        clr_cnt;
  logic [15:0] hit16;
  logic [3:0]  hit4;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hit16 = 0;
  int exp_hit4  = 0;

  logic_pipe_if #(.WIDTH(8)) bus_a ();
  logic_pipe_if #(.WIDTH(8)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.mode      = bus_a.mode;
  assign bus_b.in1       = bus_a.in1;
  assign bus_b.in2       = bus_a.in2;
  assign bus_b.in3       = bus_a.in3;
  assign bus_b.out_ready = bus_a.out_ready;

  logic_pipe #(.WIDTH(8), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus_a), .i_clr_cnt(clr_cnt), .o_hit_cnt(hit16));
  logic_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus_b), .i_clr_cnt(clr_cnt), .o_hit_cnt(hit4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour straight from the function table.
  function automatic logic [7:0] ref_out(mode_e m, logic [7:0] a, logic [7:0] b, logic [7:0] c);
    case (m)
      AND_OR:  return (a | b) & ~c;
      OR_AND:  return (a & b) | ~c;
      XOR_AND: return (a ^ b) & ~c;
      default: return ~((a | b) & c);
    endcase
  endfunction

  function automatic int ones(logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_deliver(logic [7:0] v);
    exp_hit16 = (exp_hit16 + ones(v) > 65535) ? 65535 : exp_hit16 + ones(v);
    exp_hit4  = (exp_hit4  + ones(v) > 15)    ? 15    : exp_hit4  + ones(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(mode_e m, logic [7:0] a, logic [7:0] b, logic [7:0] c);
    bus_a.in_valid = 1'b1;
    bus_a.mode     = m;
    bus_a.in1      = a;
    bus_a.in2      = b;
    bus_a.in3      = c;
  endtask

  task automatic idle();
    bus_a.in_valid = 1'b0;
  endtask

  // One beat through an otherwise empty pipe with out_ready high.
  task automatic send_one(mode_e m, logic [7:0] a, logic [7:0] b, logic [7:0] c);
    drive(m, a, b, c);
    tick();
    idle();
    tick();
    tick();
    model_deliver(ref_out(m, a, b, c));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_cnt = 1'b0;
    bus_a.out_ready = 1'b0;
    drive(AND_OR, 8'h00, 8'h00, 8'h00);
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid); end
    n_tests++; if (bus_a.out1 !== 8'h00) begin n_fail++; $display("FAIL reset_out1: got %h want 00", bus_a.out1); end
    n_tests++; if (hit16 !== 16'd0) begin n_fail++; $display("FAIL reset_hit16: got %0d want 0", hit16); end
    n_tests++; if (hit4 !== 4'd0) begin n_fail++; $display("FAIL reset_hit4: got %0d want 0", hit4); end
    rst = 1'b0;
    exp_hit16 = 0;
    exp_hit4 = 0;
    #1;
    n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus_a.in_ready); end
  endtask

  task automatic test_and_or();
    bus_a.out_ready = 1'b1;
    drive(AND_OR, 8'h0F, 8'hF0, 8'h3C);
    tick();
    idle();
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL and_or_early: out_valid %b want 0", bus_a.out_valid); end
    tick();
    n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL and_or_latency: out_valid %b want 1", bus_a.out_valid); end
    n_tests++; if (bus_a.out1 !== 8'hC3) begin n_fail++; $display("FAIL and_or_out1: got %h want c3", bus_a.out1); end
    model_deliver(8'hC3);
    tick();
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL and_or_single: out_valid %b want 0", bus_a.out_valid); end
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL and_or_hit16: got %0d want %0d", hit16, exp_hit16); end
    n_tests++; if (hit4 !== 4'(exp_hit4)) begin n_fail++; $display("FAIL and_or_hit4: got %0d want %0d", hit4, exp_hit4); end
  endtask

  task automatic test_back_to_back();
    mode_e      m_tab [3] = '{OR_AND, XOR_AND, NAND_OR};
    logic [7:0] a_tab [3] = '{8'hAA, 8'hFF, 8'h00};
    logic [7:0] b_tab [3] = '{8'h0F, 8'h0F, 8'h01};
    logic [7:0] c_tab [3] = '{8'hF0, 8'h01, 8'h01};
    logic [7:0] e_tab [3] = '{8'h0F, 8'hF0, 8'hFE};
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(m_tab[i], a_tab[i], b_tab[i], c_tab[i]);
      else idle();
      tick();
      if (i >= 1 && i <= 3) begin
        n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i - 1, bus_a.out_valid); end
        n_tests++; if (bus_a.out1 !== e_tab[i-1]) begin n_fail++; $display("FAIL b2b_out1[%0d]: got %h want %h", i - 1, bus_a.out1, e_tab[i-1]); end
        model_deliver(e_tab[i-1]);
      end
    end
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: out_valid %b want 0", bus_a.out_valid); end
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL b2b_hit16: got %0d want %0d", hit16, exp_hit16); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [3];
    mode_e m;
    logic [7:0] a, b, c;
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m = mode_e'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      e[i] = ref_out(m, a, b, c);
      drive(m, a, b, c);
      if (i < 2) tick();
    end
    #1;
    n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready %b want 0", bus_a.in_ready); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out1 !== e[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b out1 %h want 1 %h", k, bus_a.out_valid, bus_a.out1, e[0]); end
      if (k < 2) tick();
    end
    n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: in_ready %b want 0", bus_a.in_ready); end
    bus_a.out_ready = 1'b1;
    #1;
    n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready %b want 1", bus_a.in_ready); end
    tick();
    idle();
    model_deliver(e[0]);
    for (int k = 1; k < 3; k++) begin
      n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out1 !== e[k]) begin n_fail++; $display("FAIL bp_order[%0d]: valid %b out1 %h want 1 %h", k, bus_a.out_valid, bus_a.out1, e[k]); end
      model_deliver(e[k]);
      tick();
    end
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: out_valid %b want 0", bus_a.out_valid); end
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL bp_hit16: got %0d want %0d", hit16, exp_hit16); end
  endtask

  task automatic test_saturation();
    bus_a.out_ready = 1'b1;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    exp_hit16 = 0;
    exp_hit4 = 0;
    n_tests++; if (hit4 !== 4'd0 || hit16 !== 16'd0) begin n_fail++; $display("FAIL sat_clear: hit4 %0d hit16 %0d want 0 0", hit4, hit16); end
    send_one(AND_OR, 8'hFF, 8'h00, 8'h00);
    send_one(AND_OR, 8'h3F, 8'h00, 8'h00);
    n_tests++; if (hit4 !== 4'd14) begin n_fail++; $display("FAIL sat_preload: got %0d want 14", hit4); end
    send_one(AND_OR, 8'hF0, 8'h00, 8'h00);
    n_tests++; if (hit4 !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d want 15", hit4); end
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL sat_hit16: got %0d want %0d", hit16, exp_hit16); end
    send_one(AND_OR, 8'hFF, 8'h00, 8'h00);
    n_tests++; if (hit4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d want 15", hit4); end
    drive(AND_OR, 8'hFF, 8'h00, 8'h00);
    tick();
    idle();
    tick();
    clr_cnt = 1'b1;
    #1;
    n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_deliver: out_valid %b want 1", bus_a.out_valid); end
    tick();
    clr_cnt = 1'b0;
    exp_hit16 = 0;
    exp_hit4 = 0;
    n_tests++; if (hit4 !== 4'd0 || hit16 !== 16'd0) begin n_fail++; $display("FAIL sat_clr_priority: hit4 %0d hit16 %0d want 0 0", hit4, hit16); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] e;
    bus_a.out_ready = 1'b1;
    send_one(AND_OR, 8'hFF, 8'h00, 8'h00);
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL rst_pre_hit16: got %0d want %0d", hit16, exp_hit16); end
    bus_a.out_ready = 1'b0;
    drive(XOR_AND, 8'h5A, 8'h0F, 8'h00);
    tick();
    drive(OR_AND, 8'h12, 8'h34, 8'h56);
    tick();
    idle();
    n_tests++; if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_full: in_ready %b out_valid %b want 0 1", bus_a.in_ready, bus_a.out_valid); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", bus_a.out_valid); end
    n_tests++; if (hit16 !== 16'd0 || hit4 !== 4'd0) begin n_fail++; $display("FAIL rst_async_hit: hit16 %0d hit4 %0d want 0 0", hit16, hit4); end
    exp_hit16 = 0;
    exp_hit4 = 0;
    tick();
    tick();
    rst = 1'b0;
    bus_a.out_ready = 1'b1;
    e = ref_out(NAND_OR, 8'h81, 8'h42, 8'hC3);
    drive(NAND_OR, 8'h81, 8'h42, 8'hC3);
    tick();
    idle();
    n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_early: out_valid %b want 0 (stale beat)", bus_a.out_valid); end
    tick();
    n_tests++; if (bus_a.out_valid !== 1'b1 || bus_a.out1 !== e) begin n_fail++; $display("FAIL rst_after_beat: valid %b out1 %h want 1 %h", bus_a.out_valid, bus_a.out1, e); end
    model_deliver(e);
    tick();
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL rst_after_hit16: got %0d want %0d", hit16, exp_hit16); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp_v;
    logic acc, dlv, want_ready;
    int errs = 0;
    clr_cnt = 1'b1;
    idle();
    bus_a.out_ready = 1'b1;
    tick();
    clr_cnt = 1'b0;
    exp_hit16 = 0;
    exp_hit4 = 0;
    for (int cyc = 0; cyc < 620; cyc++) begin
      if (cyc < 600) begin
        bus_a.in_valid  = ($urandom_range(0, 3) != 0);
        bus_a.mode      = mode_e'($urandom_range(0, 3));
        bus_a.in1       = 8'($urandom);
        bus_a.in2       = 8'($urandom);
        bus_a.in3       = 8'($urandom);
        bus_a.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        idle();
        bus_a.out_ready = 1'b1;
      end
      #1;
      want_ready = !(q.size() >= 2 && !bus_a.out_ready);
      n_tests++; if (bus_a.in_ready !== want_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, bus_a.in_ready, want_ready); end
      acc = bus_a.in_valid && bus_a.in_ready;
      dlv = bus_a.out_valid && bus_a.out_ready;
      if (dlv) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; errs++;
          $display("FAIL rnd_spurious[%0d]: out1 %h delivered with nothing outstanding", cyc, bus_a.out1);
        end else begin
          exp_v = q.pop_front();
          if (bus_a.out1 !== exp_v) begin n_fail++; errs++; $display("FAIL rnd_out1[%0d]: got %h want %h", cyc, bus_a.out1, exp_v); end
          model_deliver(exp_v);
        end
      end
      if (acc) q.push_back(ref_out(bus_a.mode, bus_a.in1, bus_a.in2, bus_a.in3));
      @(posedge clk);
      #1;
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d beats outstanding want 0", q.size()); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL rnd_scoreboard: %0d mismatches want 0", errs); end
    n_tests++; if (hit16 !== 16'(exp_hit16)) begin n_fail++; $display("FAIL rnd_hit16: got %0d want %0d", hit16, exp_hit16); end
    n_tests++; if (hit4 !== 4'(exp_hit4)) begin n_fail++; $display("FAIL rnd_hit4: got %0d want %0d", hit4, exp_hit4); end
  endtask

  initial begin
    test_reset();
    test_and_or();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
